// File: rtl/seq_counter_pkg.sv
// Shared types and constants for the counter command scheduler.
// State encodings, default widths and requester ids.
package seq_counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_STEPW = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic [1:0] id2onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/seq_counter_sched_if.sv
// Requester handshake, counter pin drive and completion signals of the scheduler.
// master = requester/counter side, slave = scheduler side.
interface seq_counter_sched_if
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPW = DEF_STEPW
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_load;
  logic [1:0]         req_up;
  logic [2*STEPW-1:0] req_steps;
  logic [2*WIDTH-1:0] req_data;
  logic               ctr_load;
  logic               ctr_count_en;
  logic               ctr_up;
  logic [WIDTH-1:0]   ctr_data;
  logic               busy;
  logic               done;
  logic               done_id;

  modport master (
    output req_valid, req_load, req_up, req_steps, req_data,
    input  req_ready, ctr_load, ctr_count_en, ctr_up, ctr_data, busy, done, done_id
  );

  modport slave (
    input  req_valid, req_load, req_up, req_steps, req_data,
    output req_ready, ctr_load, ctr_count_en, ctr_up, ctr_data, busy, done, done_id
  );
endinterface

// File: rtl/custom_seq_counter.sv
// Up/down counter stepping through 0,2,3,6,8,9,15 with wrap; load wins over count, 1-cycle update.
// Values outside the sequence fall back to 0 on the next count step.
module CustomSeqCounter #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             count_en,
  input  logic             up,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] Q
);
  logic [WIDTH-1:0] q_q, q_d, nxt_up, nxt_dn;

  always_comb begin
    nxt_up = '0;
    nxt_dn = '0;
    unique case (q_q)
      WIDTH'(0):  begin nxt_up = WIDTH'(2);  nxt_dn = WIDTH'(15); end
      WIDTH'(2):  begin nxt_up = WIDTH'(3);  nxt_dn = WIDTH'(0);  end
      WIDTH'(3):  begin nxt_up = WIDTH'(6);  nxt_dn = WIDTH'(2);  end
      WIDTH'(6):  begin nxt_up = WIDTH'(8);  nxt_dn = WIDTH'(3);  end
      WIDTH'(8):  begin nxt_up = WIDTH'(9);  nxt_dn = WIDTH'(6);  end
      WIDTH'(9):  begin nxt_up = WIDTH'(15); nxt_dn = WIDTH'(8);  end
      WIDTH'(15): begin nxt_up = WIDTH'(0);  nxt_dn = WIDTH'(9);  end
      default:    begin nxt_up = '0;         nxt_dn = '0;         end
    endcase
    q_d = q_q;
    if (load) begin
      q_d = data_in;
    end else if (count_en) begin
      q_d = up ? nxt_up : nxt_dn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;
endmodule

// File: rtl/seq_counter_sched_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, zero latency; pointer moves only on accept.
// On a tie the requester that was not granted last wins; pointer resets to requester 1.
module rr_arb2
  import seq_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       gnt_id
);
  logic last_q, last_d;

  always_comb begin
    gnt_id = REQ0;
    if (valid == 2'b11) begin
      gnt_id = ~last_q;
    end else if (valid[1]) begin
      gnt_id = REQ1;
    end
    grant  = (|valid) ? id2onehot(gnt_id) : 2'b00;
    last_d = accept ? gnt_id : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ1;
    end else begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/seq_counter_sched.sv
// Round-robin command scheduler for one sequence counter: optional 1-cycle load, N count cycles, 1-cycle done.
// One command in flight; req_ready is high only in IDLE, so requesters hold valid until the block returns there.
module seq_counter_sched
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPW = DEF_STEPW
) (
  input  logic              Clk,
  input  logic              Reset,
  seq_counter_sched_if.slave bus
);
  state_t           state_q, state_d;
  logic             up_q, up_d;
  logic             id_q, id_d;
  logic [STEPW-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [1:0]       grant;
  logic             gnt_id;
  logic             accept;
  logic [STEPW-1:0] sel_steps;
  logic [WIDTH-1:0] sel_data;

  // Reset gates the handshake so nothing is granted during a reset cycle.
  assign accept    = (state_q == S_IDLE) && !Reset && (|bus.req_valid);
  assign sel_steps = gnt_id ? bus.req_steps[2*STEPW-1:STEPW] : bus.req_steps[STEPW-1:0];
  assign sel_data  = gnt_id ? bus.req_data[2*WIDTH-1:WIDTH]  : bus.req_data[WIDTH-1:0];

  rr_arb2 u_arb (
    .clk    (Clk),
    .reset  (Reset),
    .valid  (bus.req_valid),
    .accept (accept),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d          = state_q;
    up_d             = up_q;
    id_d             = id_q;
    rem_d            = rem_q;
    data_d           = data_q;
    bus.req_ready    = accept ? grant : 2'b00;
    bus.ctr_load     = 1'b0;
    bus.ctr_count_en = 1'b0;
    bus.ctr_up       = 1'b1;
    bus.ctr_data     = data_q;
    bus.busy         = (state_q != S_IDLE);
    bus.done         = 1'b0;
    bus.done_id      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          up_d   = bus.req_up[gnt_id];
          id_d   = gnt_id;
          rem_d  = sel_steps;
          data_d = sel_data;
          if (bus.req_load[gnt_id]) begin
            state_d = S_LOAD;
          end else if (sel_steps != '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        bus.ctr_load = 1'b1;
        state_d      = (rem_q != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        bus.ctr_count_en = 1'b1;
        bus.ctr_up       = up_q;
        rem_d            = rem_q - {{(STEPW-1){1'b0}}, 1'b1};
        if (rem_q == {{(STEPW-1){1'b0}}, 1'b1}) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.done    = 1'b1;
        bus.done_id = id_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      up_q    <= 1'b1;
      id_q    <= REQ0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_seq_counter_sched.sv
// Bench for seq_counter_sched driving CustomSeqCounter; the driver queues expected strobes/Q values
// at each accept and a separate monitor pops and compares them every cycle.
module tb_seq_counter_sched;
  localparam int EV_LOAD = 1;
  localparam int EV_RUN  = 2;
  localparam int EV_DONE = 3;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] q;
  int         cyc   = 0;
  int         tests = 0;
  int         fails = 0;
  bit         mon_en   = 1'b0;
  bit         open_cmd = 1'b0;
  ev_t        evq[$];
  ev_t        qq[$];
  int         order[$];

  seq_counter_sched_if bus ();

  seq_counter_sched dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  CustomSeqCounter u_ctr (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (bus.ctr_load),
    .count_en (bus.ctr_count_en),
    .up       (bus.ctr_up),
    .data_in  (bus.ctr_data),
    .Q        (q)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] val);
    ev_t e;
    if (evq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_strobe: kind %0d value %0d at cycle %0d, expected none", kind, val, cyc);
      return;
    end
    e = evq.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.cyc);
    chk("event_value", val, e.val);
  endtask

  // Issue one command; abort_k >= 0 asserts Reset during RUN cycle abort_k.
  task automatic send(input int id, input bit ld, input bit up, input int steps, input int data,
                      input int abort_k, input int qn, input int qv[6]);
    int c, s, n, tgt;
    bit ok;
    @(negedge Clk);
    bus.req_load[id]           = ld;
    bus.req_up[id]             = up;
    bus.req_steps[id*4 +: 4]   = 4'(steps);
    bus.req_data[id*4 +: 4]    = 4'(data);
    bus.req_valid[id]          = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (bus.req_ready[id] === 1'b1) ok = 1'b1;
      else @(negedge Clk);
    end
    chk("accept_timeout", ok, 1);
    if (!ok) begin
      bus.req_valid[id] = 1'b0;
      return;
    end
    c = cyc;
    order.push_back(id);
    s = c + 1 + int'(ld);
    n = (abort_k >= 0) ? abort_k : steps;
    if (ld) evq.push_back('{c + 1, EV_LOAD, data});
    for (int i = 0; i < n; i++) evq.push_back('{s + i, EV_RUN, int'(up)});
    if (abort_k < 0) evq.push_back('{s + n, EV_DONE, id});
    for (int i = 0; i < qn; i++) qq.push_back('{c + 2 + i, 0, qv[i]});
    @(negedge Clk);
    bus.req_valid[id] = 1'b0;
    bus.req_data[id*4 +: 4] = 4'(~data);
    if (abort_k >= 0) begin
      tgt = s + abort_k - 1;
      while (cyc < tgt) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_count_en", bus.ctr_count_en, 0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      #3;
      if (evq.size() == 0 && qq.size() == 0) break;
    end
    chk("drain_events", evq.size(), 0);
    chk("drain_q", qq.size(), 0);
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (mon_en) begin
        if (Reset) open_cmd = 1'b0;
        while (qq.size() > 0 && qq[0].cyc == cyc) begin
          e = qq.pop_front();
          chk("counter_q", q, e.val);
        end
        if (bus.ctr_load === 1'b1) expect_ev(EV_LOAD, bus.ctr_data);
        if (bus.ctr_count_en === 1'b1) expect_ev(EV_RUN, bus.ctr_up);
        if (bus.done === 1'b1) begin
          expect_ev(EV_DONE, bus.done_id);
          open_cmd = 1'b0;
        end
        chk("strobe_overlap", bus.ctr_load & bus.ctr_count_en, 0);
        if (bus.ctr_count_en !== 1'b1) chk("idle_up", bus.ctr_up, 1);
        chk("ready_onehot", bus.req_ready == 2'b11, 0);
        chk("ready_busy", bus.busy && (bus.req_ready != 2'b00), 0);
        if (bus.req_ready != 2'b00) begin
          chk("double_accept", open_cmd, 0);
          open_cmd = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    int exp_order[3];
    bus.req_valid = 2'b11;
    bus.req_load  = 2'b00;
    bus.req_up    = 2'b11;
    bus.req_steps = '0;
    bus.req_data  = '0;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_up", bus.ctr_up, 1);
    chk("rst_data", bus.ctr_data, 0);
    chk("rst_load", bus.ctr_load, 0);
    chk("rst_count_en", bus.ctr_count_en, 0);
    chk("rst_q", q, 0);
    bus.req_valid = 2'b00;
    Reset  = 1'b0;
    mon_en = 1'b1;

    send(0, 1'b1, 1'b1, 4, 6, -1, 5, '{6, 8, 9, 15, 0, 0});
    send(1, 1'b1, 1'b0, 4, 6, -1, 5, '{6, 3, 2, 0, 15, 0});
    drain();

    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    order.delete();
    exp_order = '{0, 1, 0};
    fork
      begin
        send(0, 1'b1, 1'b1, 1, 0, -1, 2, '{0, 2, 0, 0, 0, 0});
        send(0, 1'b0, 1'b1, 0, 0, -1, 0, '{0, 0, 0, 0, 0, 0});
      end
      begin
        send(1, 1'b1, 1'b0, 2, 8, -1, 3, '{8, 6, 3, 0, 0, 0});
      end
    join
    drain();
    chk("fair_count", order.size(), 3);
    for (int i = 0; i < order.size() && i < 3; i++) chk("fair_order", order[i], exp_order[i]);

    send(0, 1'b0, 1'b1, 0, 0, -1, 0, '{0, 0, 0, 0, 0, 0});
    send(1, 1'b1, 1'b1, 0, 9, -1, 1, '{9, 0, 0, 0, 0, 0});
    drain();

    send(0, 1'b1, 1'b1, 4, 0, 3, 4, '{0, 2, 3, 0, 0, 0});
    send(1, 1'b0, 1'b1, 2, 0, -1, 2, '{2, 3, 0, 0, 0, 0});
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_counter_sched.md
# seq_counter_sched

Command scheduler for the custom-sequence up/down counter (`CustomSeqCounter`).
- Two requesters share one counter instance.
- Each request is a small command: optional load, then N count steps up or down.
- The block arbitrates round-robin and accepts one command at a time over a valid/ready handshake.
- It drives the counter's `load`/`count_en`/`up`/`data_in` pins cycle by cycle and signals completion with a one-cycle `done` pulse tagged with the requester id.

## Interface
- `WIDTH`, 4: counter data width; must equal the counter's `WIDTH`.
- `STEPW`, 4: width of step-count field; max 2^STEPW−1 steps per command.

Ports:
- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  bit i = requester i has a command.
- `req_ready`  out  2  bit i = command i accepted this cycle (one-hot or zero).
- `req_load`  in  2  bit i = load `data` before counting.
- `req_up`  in  2  bit i = count direction (1 up, 0 down).
- `req_steps`  in  2*STEPW  slice i = number of count_en cycles.
- `req_data`  in  2*WIDTH  slice i = load value.
- `ctr_load`  out  1  to counter `load`.
- `ctr_count_en`  out  1  to counter `count_en`.
- `ctr_up`  out  1  to counter `up`.
- `ctr_data`  out  WIDTH  to counter `data_in`.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `done_id`  out  1  requester of completed command; valid when `done`=1.

## Operation
**FSM states:** IDLE, LOAD, RUN, DONE.

**IDLE**
- If any `req_valid` is high, grant one requester g and assert `req_ready[g]` combinationally in that cycle.
- At the edge, latch `load`, `up`, `steps` and `data`, and record g.
- Next state:
  - LOAD if `load`=1.
  - Else RUN if `steps`≠0.
  - Else DONE.

**LOAD**
- `ctr_load`=1 and `ctr_data`=latched data for exactly one cycle.
- Next state: RUN if `steps`≠0, else DONE.

**RUN**
- `ctr_count_en`=1 and `ctr_up`=latched up.
- A remaining-step counter starts at `steps` and decrements each cycle.
- Next state: DONE when remaining==1.

**DONE**
- `done`=1 and `done_id`=g for one cycle.
- Next state: always IDLE.

**Arbitration**
- Round-robin with a last-grant pointer, updated only on accept.
- When both requesters are valid, the non-last-granted one wins.
- The pointer resets to 1, so req0 wins the first tie.

**Handshake**
- Commands are accepted only in IDLE.
- `req_ready` is 0 in every other state.
- A requester holds `valid` and its fields stable until it sees `ready`.
- Command fields are captured at accept; later changes to them are ignored.

**Counter pin rules**
- `ctr_load` and `ctr_count_en` are never asserted together.
- Outside RUN, `ctr_count_en`=0 and `ctr_up`=1.
- `ctr_data` holds the last latched data.

**Reset**
- Applies at the next rising edge:
  - State → IDLE.
  - `ctr_load`, `ctr_count_en`, `busy`, `done`, `done_id`, `req_ready` → 0.
  - `ctr_up` → 1.
  - `ctr_data` → 0.
  - Step counter → 0.
  - Pointer → 1.
- Reset mid-command drops the command silently: no `done`.
- Reset has priority over every other event.

## Timing
Cycle 0 = accept cycle (`req_valid[g]` & `req_ready[g]`).

| Command type | LOAD cycle | RUN cycles | DONE cycle | Next accept (earliest) |
|---|---|---|---|---|
| With load, N≥1 | 1 | 2..N+1 | N+2 | N+3 |
| Without load, N≥1 | — | 1..N | N+1 | N+2 |
| Load, N=0 | 1 | — | 2 | 3 |
| Null (no load, N=0) | — | — | 1 | 2 |

- The counter's Q reflects each LOAD/RUN cycle's action one edge later.
- Throughput: one command per (latency+1) cycles; there is no command queue.

## Structure
- Package `seq_counter_pkg` holds:
  - State encodings `S_IDLE`=2'd0, `S_LOAD`=2'd1, `S_RUN`=2'd2, `S_DONE`=2'd3.
  - Default `WIDTH`/`STEPW`.
  - Requester id constants.
- Sub-module `rr_arb2`: 2-input round-robin arbiter (valid in, one-hot grant out, pointer update on accept).
- The FSM, command latch and step counter live in `seq_counter_sched`.
- The bench instantiates this block driving a `CustomSeqCounter` (sequence 0,2,3,6,8,9,15).

## Test plan
1. **Reset:** `Reset`=1 for 2 edges with `req_valid`=2'b11 → `req_ready`=0, `busy`=0, `done`=0, `ctr_up`=1, `ctr_data`=0, all counter strobes 0.
2. **Load then count up:** req0 with load=1, data=6, up=1, steps=4 → `ctr_load` in cycle 1 with `ctr_data`=6, `count_en` in cycles 2–5, `done`/`done_id`=0 in cycle 6. Counter Q goes 6,8,9,15,0.
3. **Load then count down:** req1 with load=1, data=6, up=0, steps=4 → Q goes 6,3,2,0,15; `done_id`=1 in cycle 6.
4. **Fairness:** both requesters valid after reset → req0 granted first, then req1 at the next IDLE, then req0; never two accepts without DONE between them.
5. **Edge commands:** null command → `done` in cycle 1 with no strobes. Load-only with data=9 → `ctr_load` in cycle 1, `done` in cycle 2, Q=9.
6. **Reset mid-RUN:** `Reset` asserted during RUN cycle 3 of a steps=4 command → `count_en`=0 and IDLE after the edge, no `done`, next command accepted normally.
